// File: rtl/glyph_fetch.sv
// glyph_fetch: pixel-pipeline stage between the VGA sync generator and the
// RGB pins of the clock display. For each scanned pixel it decides which
// character slot is under the beam (six time digits or one symbol), puts that
// slot's code on Value, takes the glyph y-offset back on PointY, forms the
// font-ROM address, then turns the returned ROM bit into a colour. Sync
// signals are delayed so they stay aligned with rgb (2 pixel_ticks).
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   pixel_tick              pixel enable; every register advances only on it
//   video_on                visible-area flag
//   pixel_x, pixel_y        current scan position
//   hsync_in, vsync_in      undelayed syncs
//   digit_codes             six 4-bit digit codes, slot k = [4k+3:4k]
//   sym_code                symbol code
//   Value                   active slot code, 15 when no slot (combinational)
//   PointY                  glyph y-offset from the pointer table (combinational)
//   digit_addr, digit_bit   digit ROM address (registered) / data (1 clk later)
//   sym_addr, sym_bit       symbol ROM address (registered) / data (1 clk later)
//   rgb                     pixel colour
//   hsync_out, vsync_out    syncs delayed 2 pixel_ticks
//
// Handshake: there is no valid/ready flow control. pixel_tick acts as a
// single-cycle enable; data presented while pixel_tick=0 is ignored and all
// state holds.
module glyph_fetch #(
  parameter int          X0      = 160,
  parameter int          Y0      = 210,
  parameter int          DIGIT_W = 40,
  parameter int          DIGIT_H = 60,
  parameter int          GAP     = 8,
  parameter int          SYM_X   = 480,
  parameter int          SYM_Y   = 230,
  parameter int          SYM_W   = 48,
  parameter int          SYM_H   = 20,
  parameter logic [7:0]  FG_RGB  = 8'hFF,
  parameter logic [7:0]  SYM_RGB = 8'h1C,
  parameter logic [7:0]  BG_RGB  = 8'h00
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pixel_tick,
  input  logic        video_on,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        hsync_in,
  input  logic        vsync_in,
  input  logic [23:0] digit_codes,
  input  logic [3:0]  sym_code,
  output logic [3:0]  Value,
  input  logic [9:0]  PointY,
  output logic [14:0] digit_addr,
  input  logic        digit_bit,
  output logic [10:0] sym_addr,
  input  logic        sym_bit,
  output logic [7:0]  rgb,
  output logic        hsync_out,
  output logic        vsync_out
);

  localparam int PITCH = DIGIT_W + GAP;

  typedef enum logic [1:0] {
    KIND_NONE  = 2'd0,
    KIND_DIGIT = 2'd1,
    KIND_SYM   = 2'd2
  } kind_t;

  // Stage 0: slot decode (combinational)
  kind_t       hit_kind;
  logic [9:0]  col;
  logic [9:0]  row;
  logic [10:0] row_sum;

  always_comb begin
    logic [9:0] left;
    logic       digit_row;
    hit_kind = KIND_NONE;
    Value    = 4'd15;
    col      = '0;
    row      = '0;
    left     = '0;
    // Compare in 11 bits so a slot ending near the right edge cannot wrap.
    digit_row = ({1'b0, pixel_y} >= 11'(Y0)) &&
                ({1'b0, pixel_y} <  11'(Y0 + DIGIT_H));
    for (int k = 0; k < 6; k++) begin
      left = 10'(X0 + k * PITCH);
      if (digit_row &&
          ({1'b0, pixel_x} >= {1'b0, left}) &&
          ({1'b0, pixel_x} <  {1'b0, left} + 11'(DIGIT_W))) begin
        hit_kind = KIND_DIGIT;
        Value    = digit_codes[4*k +: 4];
        col      = pixel_x - left;
        row      = pixel_y - 10'(Y0);
      end
    end
    if (({1'b0, pixel_x} >= 11'(SYM_X)) && ({1'b0, pixel_x} < 11'(SYM_X + SYM_W)) &&
        ({1'b0, pixel_y} >= 11'(SYM_Y)) && ({1'b0, pixel_y} < 11'(SYM_Y + SYM_H))) begin
      hit_kind = KIND_SYM;
      Value    = sym_code;
      col      = pixel_x - 10'(SYM_X);
      row      = pixel_y - 10'(SYM_Y);
    end
  end

  // Glyph line = table offset plus row inside the slot; 11 bits holds the
  // largest PointY plus any row without wrap.
  assign row_sum = {1'b0, PointY} + {1'b0, row};

  // Stage 1 / stage 2 pipeline registers
  kind_t s1_kind;
  logic  s1_video;
  logic  s1_hsync;
  logic  s1_vsync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_kind    <= KIND_NONE;
      s1_video   <= 1'b0;
      s1_hsync   <= 1'b1;
      s1_vsync   <= 1'b1;
      digit_addr <= '0;
      sym_addr   <= '0;
      rgb        <= '0;
      hsync_out  <= 1'b1;
      vsync_out  <= 1'b1;
    end else if (pixel_tick) begin
      // Stage 1: the product is formed at full width and only the final sum
      // is cut to the ROM address width. Each address holds when its slot
      // kind is not hit, so the ROM output stays stable over background.
      if (hit_kind == KIND_DIGIT)
        digit_addr <= 15'(20'(row_sum) * 20'(DIGIT_W) + 20'(col));
      if (hit_kind == KIND_SYM)
        sym_addr <= 11'(20'(row_sum) * 20'(SYM_W) + 20'(col));
      s1_kind  <= hit_kind;
      s1_video <= video_on;
      s1_hsync <= hsync_in;
      s1_vsync <= vsync_in;

      // Stage 2: ROM bits belong to the addresses registered one tick ago.
      if (!s1_video)
        rgb <= 8'h00;
      else begin
        case (s1_kind)
          KIND_DIGIT: rgb <= digit_bit ? FG_RGB  : BG_RGB;
          KIND_SYM:   rgb <= sym_bit   ? SYM_RGB : BG_RGB;
          default:    rgb <= BG_RGB;
        endcase
      end
      hsync_out <= s1_hsync;
      vsync_out <= s1_vsync;
    end
  end

endmodule

// File: tb/tb_glyph_fetch.sv
module tb_glyph_fetch;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        pixel_tick = 1'b0;
  logic        video_on = 1'b0;
  logic [9:0]  pixel_x = '0;
  logic [9:0]  pixel_y = '0;
  logic        hsync_in = 1'b1;
  logic        vsync_in = 1'b1;
  logic [23:0] digit_codes = '0;
  logic [3:0]  sym_code = '0;
  logic [3:0]  Value;
  logic [9:0]  PointY;
  logic [14:0] digit_addr;
  logic        digit_bit;
  logic [10:0] sym_addr;
  logic        sym_bit;
  logic [7:0]  rgb;
  logic        hsync_out;
  logic        vsync_out;

  glyph_fetch dut (
    .clk(clk), .rst_n(rst_n), .pixel_tick(pixel_tick), .video_on(video_on),
    .pixel_x(pixel_x), .pixel_y(pixel_y), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .digit_codes(digit_codes), .sym_code(sym_code), .Value(Value), .PointY(PointY),
    .digit_addr(digit_addr), .digit_bit(digit_bit), .sym_addr(sym_addr),
    .sym_bit(sym_bit), .rgb(rgb), .hsync_out(hsync_out), .vsync_out(vsync_out)
  );

  // Pointer table and font ROMs (environment models)
  logic [9:0] ptr_tab [16];
  int         rom_mode = 0;   // 0: hash pattern, 1: all ones, 2: all zeros

  assign PointY    = ptr_tab[Value];
  assign digit_bit = (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? 1'b0 :
                     (digit_addr[0] ^ digit_addr[3] ^ digit_addr[6] ^ digit_addr[9]);
  assign sym_bit   = (rom_mode == 1) ? 1'b1 : (rom_mode == 2) ? 1'b0 :
                     (sym_addr[0] ^ sym_addr[3] ^ sym_addr[6] ^ sym_addr[9]);

  function automatic logic rom_bit(input int a);
    if (rom_mode == 1) return 1'b1;
    if (rom_mode == 2) return 1'b0;
    return a[0] ^ a[3] ^ a[6] ^ a[9];
  endfunction

  // Scoreboard
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model. A queue entry is one accepted pixel:
  // {kind[1:0], video, hsync, vsync, addr[14:0]}; it reaches the outputs one
  // tick after it is queued (the second tick after its pixel was presented).
  logic [19:0] exp_q[$];
  int m_daddr, m_saddr, cur_rgb, cur_hs, cur_vs;

  task automatic model_reset();
    exp_q.delete();
    exp_q.push_back({2'd0, 1'b0, 1'b1, 1'b1, 15'd0});
    m_daddr = 0; m_saddr = 0; cur_rgb = 0; cur_hs = 1; cur_vs = 1;
  endtask

  // Slot geometry straight from the screen layout.
  task automatic classify(input int x, input int y,
                          output int kind, output int code, output int col, output int row);
    kind = 0; code = 15; col = 0; row = 0;
    for (int k = 0; k < 6; k++) begin
      int left = 160 + 48 * k;
      if (x >= left && x < left + 40 && y >= 210 && y < 270) begin
        kind = 1; code = (digit_codes >> (4 * k)) & 15; col = x - left; row = y - 210;
      end
    end
    if (x >= 480 && x < 528 && y >= 230 && y < 250) begin
      kind = 2; code = sym_code; col = x - 480; row = y - 230;
    end
  endtask

  task automatic check_outputs(input string tag);
    check({tag, "_rgb"}, int'(rgb), cur_rgb);
    check({tag, "_hs"}, int'(hsync_out), cur_hs);
    check({tag, "_vs"}, int'(vsync_out), cur_vs);
    check({tag, "_daddr"}, int'(digit_addr), m_daddr);
    check({tag, "_saddr"}, int'(sym_addr), m_saddr);
  endtask

  // Driver: one clock with the currently driven inputs, then model + compare.
  task automatic step(input string tag);
    int kind, code, col, row, addr;
    logic [19:0] item, head;
    #1;
    classify(int'(pixel_x), int'(pixel_y), kind, code, col, row);
    check({tag, "_value"}, int'(Value), code);
    addr = 0;
    if (pixel_tick && kind == 1) m_daddr = ((int'(ptr_tab[code]) + row) * 40 + col) % 32768;
    if (pixel_tick && kind == 2) m_saddr = ((int'(ptr_tab[code]) + row) * 48 + col) % 2048;
    addr = (kind == 2) ? m_saddr : m_daddr;
    item = {2'(kind), video_on, hsync_in, vsync_in, 15'(addr)};
    @(posedge clk);
    #1;
    if (pixel_tick) begin
      exp_q.push_back(item);
      head = exp_q.pop_front();
      if (!head[17])              cur_rgb = 0;
      else if (head[19:18] == 1)  cur_rgb = rom_bit(int'(head[14:0])) ? 8'hFF : 8'h00;
      else if (head[19:18] == 2)  cur_rgb = rom_bit(int'(head[14:0])) ? 8'h1C : 8'h00;
      else                        cur_rgb = 0;
      cur_hs = head[16];
      cur_vs = head[15];
    end
    check_outputs(tag);
  endtask

  task automatic set_pixel(input int x, input int y, input logic vid, input logic tick);
    pixel_x = 10'(x); pixel_y = 10'(y); video_on = vid; pixel_tick = tick;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ptr_tab[i] = '0;
    model_reset();
    #22;
    check_outputs("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // Slot 0, code 7, offset 420
    rom_mode = 1; digit_codes = 24'h000007; ptr_tab[7] = 10'd420;
    set_pixel(160, 210, 1'b1, 1'b1);
    step("t1a");
    check("t1_daddr", int'(digit_addr), 16800);
    set_pixel(10, 10, 1'b1, 1'b1);
    step("t1b");
    check("t1_rgb", int'(rgb), 8'hFF);

    // Slot 2, code 3, offset 180, ROM bit 0
    rom_mode = 2; digit_codes = 24'h000300; ptr_tab[3] = 10'd180;
    set_pixel(261, 220, 1'b1, 1'b1);
    step("t2a");
    check("t2_daddr", int'(digit_addr), 7605);
    set_pixel(10, 10, 1'b1, 1'b1);
    step("t2b");
    check("t2_rgb", int'(rgb), 8'h00);

    // Symbol slot, PM code 11, offset 20
    rom_mode = 1; sym_code = 4'd11; ptr_tab[11] = 10'd20;
    set_pixel(483, 234, 1'b1, 1'b1);
    step("t3a");
    check("t3_saddr", int'(sym_addr), 1155);
    step("t3b");
    check("t3_rgb", int'(rgb), 8'h1C);

    // Slot edges
    digit_codes = 24'h000005; ptr_tab[5] = 10'd60;
    set_pixel(199, 210, 1'b1, 1'b1);
    #1 check("x199_value", int'(Value), 5);
    step("x199");
    step("x199b");
    check("x199_rgb", int'(rgb), 8'hFF);
    for (int x = 200; x < 208; x++) begin
      set_pixel(x, 240, 1'b1, 1'b1);
      #1 check("gap_value", int'(Value), 15);
      step("gap");
    end
    check("gap_rgb", int'(rgb), 8'h00);
    set_pixel(170, 270, 1'b1, 1'b1);
    #1 check("y270_value", int'(Value), 15);
    step("y270a");
    step("y270b");
    check("y270_rgb", int'(rgb), 8'h00);
    set_pixel(170, 269, 1'b1, 1'b1);
    step("y269a");
    step("y269b");
    check("y269_rgb", int'(rgb), 8'hFF);
    set_pixel(170, 240, 1'b0, 1'b1);
    step("vid0a");
    step("vid0b");
    check("vid0_rgb", int'(rgb), 8'h00);

    // Hold: no pixel_tick while inputs move
    set_pixel(165, 215, 1'b1, 1'b1);
    step("pre_hold");
    for (int i = 0; i < 5; i++) begin
      set_pixel($urandom_range(0, 799), $urandom_range(0, 524), 1'($urandom_range(0, 1)), 1'b0);
      hsync_in = 1'($urandom_range(0, 1)); vsync_in = 1'($urandom_range(0, 1));
      step("hold");
    end

    // hsync pulse delay
    hsync_in = 1'b1; vsync_in = 1'b1;
    set_pixel(10, 10, 1'b1, 1'b1);
    step("hs0"); step("hs1");
    hsync_in = 1'b0;
    step("hsA");
    check("hs_pulse_t1", int'(hsync_out), 1);
    hsync_in = 1'b1;
    step("hsB");
    check("hs_pulse_t2", int'(hsync_out), 0);
    step("hsC");
    check("hs_pulse_t3", int'(hsync_out), 1);

    // Mid-line reset
    hsync_in = 1'b0; vsync_in = 1'b0;
    set_pixel(170, 240, 1'b1, 1'b1);
    step("prer1"); step("prer2");
    #2 rst_n = 1'b0;
    #1;
    check("rst_rgb", int'(rgb), 0);
    check("rst_hs", int'(hsync_out), 1);
    check("rst_vs", int'(vsync_out), 1);
    model_reset();
    check_outputs("rst");
    @(negedge clk);
    rst_n = 1'b1;
    hsync_in = 1'b1; vsync_in = 1'b1;
    step("post1");
    check("post1_rgb", int'(rgb), 0);
    step("post2");
    check("post2_rgb", int'(rgb), 8'hFF);

    // Randomized traffic
    rom_mode = 0;
    for (int i = 0; i < 16; i++) ptr_tab[i] = 10'($urandom_range(0, 1023));
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        digit_codes = 24'($urandom());
        sym_code    = 4'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 1) == 1)
        set_pixel($urandom_range(150, 540), $urandom_range(200, 280),
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0));
      else
        set_pixel($urandom_range(0, 799), $urandom_range(0, 524),
                  1'($urandom_range(0, 9) != 0), 1'($urandom_range(0, 3) != 0));
      hsync_in = 1'($urandom_range(0, 7) != 0);
      vsync_in = 1'($urandom_range(0, 7) != 0);
      step("rand");
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
